// File: rtl/port_ingress_buffer.sv
// port_ingress_buffer: store-and-forward ingress FIFO that keeps a packet's words only once the whole packet checks out.
// Payload goes in at a speculative pointer and is either committed with a descriptor or rolled back and counted as a drop.
module port_ingress_buffer #(
    parameter int DW        = 16,
    parameter int AW        = 4,
    parameter int PW        = 3,
    parameter int LW        = 9,
    parameter int DEPTH     = 64,
    parameter int PKT_DEPTH = 4,
    parameter int PAUSE_GAP = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_sop,
    input  logic          wr_eop,
    input  logic          wr_vld,
    input  logic [DW-1:0] wr_data,
    output logic          pause,
    output logic          pkt_vld,
    output logic [AW-1:0] pkt_dest,
    output logic [PW-1:0] pkt_prio,
    output logic [LW-1:0] pkt_len,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_vld,
    output logic          rd_last,
    output logic          drop_pulse,
    output logic [15:0]   drop_cnt
);
    localparam int AB   = $clog2(DEPTH);
    localparam int PTRW = AB + 1;
    localparam int DB   = $clog2(PKT_DEPTH);
    localparam int DPW  = DB + 1;
    localparam int CW   = (LW > PTRW) ? LW : PTRW;

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DROP} state_t;

    state_t state, nxt;

    logic [DW-1:0] mem [DEPTH];
    logic [LW-1:0] d_len  [PKT_DEPTH];
    logic [PW-1:0] d_prio [PKT_DEPTH];
    logic [AW-1:0] d_dest [PKT_DEPTH];

    logic [PTRW-1:0] wp_s, wp_c, rp, occ, free, wp_s_n;
    logic [DPW-1:0]  dwp, drp;
    logic [CW-1:0]   cnt, cnt_n;
    logic [LW-1:0]   len_r, rd_idx;
    logic [PW-1:0]   prio_r;
    logic [AW-1:0]   dest_r;
    logic [LW-1:0]   h_len;
    logic [PW-1:0]   h_prio;
    logic [AW-1:0]   h_dest;
    logic full, dfull, hdr_bad, hdr_ld, wr_ok, commit, drop, rd_fire, last_n, pop;

    assign h_len  = wr_data[DW-1 -: LW];
    assign h_prio = wr_data[DW-LW-1 -: PW];
    assign h_dest = wr_data[DW-LW-PW-1 -: AW];

    assign occ     = wp_s - rp;
    assign free    = PTRW'(DEPTH) - occ;
    assign full    = occ == PTRW'(DEPTH);
    assign dfull   = (dwp - drp) == DPW'(PKT_DEPTH);
    assign hdr_bad = (h_len == '0) || (CW'(h_len) > CW'(DEPTH)) || dfull;

    assign pkt_vld  = dwp != drp;
    assign pkt_len  = pkt_vld ? d_len[drp[DB-1:0]]  : '0;
    assign pkt_prio = pkt_vld ? d_prio[drp[DB-1:0]] : '0;
    assign pkt_dest = pkt_vld ? d_dest[drp[DB-1:0]] : '0;
    assign rd_fire  = rd_en && pkt_vld;
    assign last_n   = rd_idx == pkt_len - LW'(1);
    assign pop      = rd_fire && last_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // A fresh sop always wins: it aborts whatever packet is in flight and restarts header capture.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = wr_sop ? HEADER : IDLE;
            HEADER:  nxt = wr_sop ? HEADER : !wr_vld ? HEADER : hdr_bad ? DROP : PAYLOAD;
            PAYLOAD: nxt = wr_sop ? HEADER : (wr_vld && full && !wr_eop) ? DROP : wr_eop ? IDLE : PAYLOAD;
            DROP:    nxt = wr_sop ? HEADER : wr_eop ? IDLE : DROP;
            default: nxt = IDLE;
        endcase
    end

    // The eop-cycle word is counted before the length check so a trailing word with eop still commits.
    always_comb begin
        hdr_ld = (state == HEADER) && !wr_sop && wr_vld;
        wr_ok  = (state == PAYLOAD) && !wr_sop && wr_vld && !full;
        cnt_n  = cnt + CW'(wr_ok);
        wp_s_n = wp_s + PTRW'(wr_ok);
        commit = (state == PAYLOAD) && !wr_sop && wr_eop && !(wr_vld && full) && (cnt_n == CW'(len_r));
        drop   = ((state == HEADER) && wr_sop)
              || ((state == PAYLOAD) && (wr_sop || (wr_eop && !commit)))
              || ((state == DROP) && (wr_sop || wr_eop));
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wp_s[AB-1:0]] <= wr_data;
        if (commit) begin
            d_len[dwp[DB-1:0]]  <= len_r;
            d_prio[dwp[DB-1:0]] <= prio_r;
            d_dest[dwp[DB-1:0]] <= dest_r;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_s       <= '0;
            wp_c       <= '0;
            rp         <= '0;
            dwp        <= '0;
            drp        <= '0;
            cnt        <= '0;
            len_r      <= '0;
            prio_r     <= '0;
            dest_r     <= '0;
            rd_idx     <= '0;
            rd_data    <= '0;
            rd_vld     <= 1'b0;
            rd_last    <= 1'b0;
            pause      <= 1'b0;
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            wp_s       <= drop ? wp_c : wp_s_n;
            wp_c       <= commit ? wp_s_n : wp_c;
            rp         <= rp + PTRW'(rd_fire);
            dwp        <= dwp + DPW'(commit);
            drp        <= drp + DPW'(pop);
            cnt        <= (state == PAYLOAD && nxt == PAYLOAD) ? cnt_n : '0;
            len_r      <= hdr_ld ? h_len : len_r;
            prio_r     <= hdr_ld ? h_prio : prio_r;
            dest_r     <= hdr_ld ? h_dest : dest_r;
            rd_idx     <= !rd_fire ? rd_idx : last_n ? '0 : rd_idx + LW'(1);
            rd_data    <= rd_fire ? mem[rp[AB-1:0]] : rd_data;
            rd_vld     <= rd_fire;
            rd_last    <= pop;
            pause      <= (int'(free) < PAUSE_GAP) || dfull;
            drop_pulse <= drop;
            drop_cnt   <= (drop && drop_cnt != 16'hFFFF) ? drop_cnt + 16'd1 : drop_cnt;
        end
    end
endmodule

// File: tb/tb_port_ingress_buffer.sv
// tb_port_ingress_buffer: directed packet scenarios with hand-computed descriptors, data and drop counts.
module tb_port_ingress_buffer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_sop = 1'b0, wr_eop = 1'b0, wr_vld = 1'b0, rd_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic        pause, pkt_vld, rd_vld, rd_last, drop_pulse;
    logic [3:0]  pkt_dest;
    logic [2:0]  pkt_prio;
    logic [8:0]  pkt_len;
    logic [15:0] rd_data, drop_cnt;
    int          total = 0;
    int          bad = 0;

    port_ingress_buffer dut (
        .clk(clk), .rst_n(rst_n), .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_vld(wr_vld),
        .wr_data(wr_data), .pause(pause), .pkt_vld(pkt_vld), .pkt_dest(pkt_dest),
        .pkt_prio(pkt_prio), .pkt_len(pkt_len), .rd_en(rd_en), .rd_data(rd_data),
        .rd_vld(rd_vld), .rd_last(rd_last), .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] hdr(input int l, input int p, input int d);
        return {l[8:0], p[2:0], d[3:0]};
    endfunction

    task automatic tick(input logic s, input logic e, input logic v, input logic [15:0] d);
        wr_sop = s; wr_eop = e; wr_vld = v; wr_data = d;
        @(posedge clk); #1;
        wr_sop = 1'b0; wr_eop = 1'b0; wr_vld = 1'b0;
    endtask

    task automatic send(input int l, input int p, input int d, input int n, input int base, input bit eop_last);
        tick(1'b1, 1'b0, 1'b0, 16'h0);
        tick(1'b0, 1'b0, 1'b1, hdr(l, p, d));
        for (int i = 0; i < n; i++) tick(1'b0, eop_last && i == n - 1, 1'b1, 16'(base + i));
        if (!eop_last) tick(1'b0, 1'b1, 1'b0, 16'h0);
    endtask

    task automatic rd_pkt(input int n, input int base, input string tag);
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1;
            @(posedge clk); #1;
            rd_en = 1'b0;
            chk({tag, "_data"}, 32'(rd_data), 32'(16'(base + i)));
            chk({tag, "_vld"}, 32'(rd_vld), 32'd1);
            chk({tag, "_last"}, 32'(rd_last), 32'(i == n - 1));
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pause", 32'(pause), 0);
        chk("rst_pkt_vld", 32'(pkt_vld), 0);
        chk("rst_rd_vld", 32'(rd_vld), 0);
        chk("rst_rd_last", 32'(rd_last), 0);
        chk("rst_drop_pulse", 32'(drop_pulse), 0);
        chk("rst_drop_cnt", 32'(drop_cnt), 0);
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 16'h0);

        // basic 31-word packet
        tick(1'b1, 1'b0, 1'b0, 16'h0);
        tick(1'b0, 1'b0, 1'b1, hdr(31, 4, 3));
        for (int i = 1; i <= 31; i++) tick(1'b0, 1'b0, 1'b1, 16'(i));
        chk("p31_pre_eop_vld", 32'(pkt_vld), 0);
        tick(1'b0, 1'b1, 1'b0, 16'h0);
        chk("p31_vld", 32'(pkt_vld), 1);
        chk("p31_dest", 32'(pkt_dest), 3);
        chk("p31_prio", 32'(pkt_prio), 4);
        chk("p31_len", 32'(pkt_len), 31);
        rd_pkt(31, 1, "p31");
        chk("p31_empty", 32'(pkt_vld), 0);

        // short packet: 4 of 5 words
        send(5, 1, 1, 4, 16'h0500, 1'b0);
        chk("short_drop_pulse", 32'(drop_pulse), 1);
        chk("short_drop_cnt", 32'(drop_cnt), 1);
        chk("short_pkt_vld", 32'(pkt_vld), 0);
        tick(1'b0, 1'b0, 1'b0, 16'h0);
        chk("short_pulse_once", 32'(drop_pulse), 0);

        // 60-word packet drives pause
        tick(1'b1, 1'b0, 1'b0, 16'h0);
        tick(1'b0, 1'b0, 1'b1, hdr(60, 2, 5));
        for (int i = 0; i < 56; i++) tick(1'b0, 1'b0, 1'b1, 16'(100 + i));
        tick(1'b0, 1'b0, 1'b0, 16'h0);
        chk("p60_pause_at_8_free", 32'(pause), 0);
        for (int i = 56; i < 60; i++) tick(1'b0, 1'b0, 1'b1, 16'(100 + i));
        tick(1'b0, 1'b1, 1'b0, 16'h0);
        chk("p60_pause", 32'(pause), 1);
        chk("p60_vld", 32'(pkt_vld), 1);
        chk("p60_len", 32'(pkt_len), 60);
        rd_pkt(60, 100, "p60");
        tick(1'b0, 1'b0, 1'b0, 16'h0);
        chk("p60_pause_clear", 32'(pause), 0);

        // len=2 with eop on the last word
        send(2, 6, 9, 2, 16'h00A1, 1'b1);
        chk("p2_vld", 32'(pkt_vld), 1);
        chk("p2_len", 32'(pkt_len), 2);
        chk("p2_drop_cnt", 32'(drop_cnt), 1);
        rd_pkt(2, 16'h00A1, "p2");

        // sop mid-payload aborts and restarts
        tick(1'b1, 1'b0, 1'b0, 16'h0);
        tick(1'b0, 1'b0, 1'b1, hdr(4, 1, 1));
        tick(1'b0, 1'b0, 1'b1, 16'h0051);
        tick(1'b0, 1'b0, 1'b1, 16'h0052);
        tick(1'b1, 1'b0, 1'b0, 16'h0);
        chk("abort_drop_pulse", 32'(drop_pulse), 1);
        chk("abort_drop_cnt", 32'(drop_cnt), 2);
        tick(1'b0, 1'b0, 1'b1, hdr(2, 2, 2));
        tick(1'b0, 1'b0, 1'b1, 16'h0061);
        tick(1'b0, 1'b1, 1'b1, 16'h0062);
        chk("abort_new_vld", 32'(pkt_vld), 1);
        chk("abort_new_dest", 32'(pkt_dest), 2);
        rd_pkt(2, 16'h0061, "abort_new");

        // zero-length header is dropped
        send(0, 1, 1, 0, 0, 1'b0);
        chk("len0_drop_cnt", 32'(drop_cnt), 3);
        chk("len0_pkt_vld", 32'(pkt_vld), 0);

        // descriptor FIFO full
        for (int k = 1; k <= 4; k++) send(3, k, k + 5, 3, 16 * k, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 16'h0);
        chk("dfull_pause", 32'(pause), 1);
        send(3, 7, 9, 3, 16'h0077, 1'b0);
        chk("dfull_drop_pulse", 32'(drop_pulse), 1);
        chk("dfull_drop_cnt", 32'(drop_cnt), 4);
        for (int k = 1; k <= 4; k++) begin
            chk("dfull_dest", 32'(pkt_dest), 32'(k + 5));
            chk("dfull_prio", 32'(pkt_prio), 32'(k));
            chk("dfull_len", 32'(pkt_len), 3);
            rd_pkt(3, 16 * k, "dfull");
        end
        chk("dfull_empty", 32'(pkt_vld), 0);

        // read with nothing committed is ignored
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        chk("empty_rd_vld", 32'(rd_vld), 0);
        tick(1'b0, 1'b0, 1'b0, 16'h0);
        chk("dfull_pause_clear", 32'(pause), 0);

        // reset mid-payload
        tick(1'b1, 1'b0, 1'b0, 16'h0);
        tick(1'b0, 1'b0, 1'b1, hdr(20, 1, 1));
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b1, 16'(200 + i));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_drop_cnt", 32'(drop_cnt), 0);
        chk("mid_rst_pkt_vld", 32'(pkt_vld), 0);
        chk("mid_rst_pause", 32'(pause), 0);
        chk("mid_rst_drop_pulse", 32'(drop_pulse), 0);
        chk("mid_rst_rd_vld", 32'(rd_vld), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 16'h0);
        send(3, 3, 3, 3, 16'h0300, 1'b0);
        chk("post_rst_vld", 32'(pkt_vld), 1);
        chk("post_rst_len", 32'(pkt_len), 3);
        chk("post_rst_drop_cnt", 32'(drop_cnt), 0);
        rd_pkt(3, 16'h0300, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
